// File: rtl/fwd_lookup_ctrl.sv
// Forward-path lookup controller: two-stage valid/ready pipeline in front of the lookup table.
// Optional hit/miss statistics are compiled in with `define FWD_LOOKUP_STATS_EN.
module fwd_lookup_ctrl #(
  parameter int TAG_W       = 8,
  parameter int CHANNEL_NUM = 4
`ifdef FWD_LOOKUP_STATS_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_addr,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     fwd_rden,
  output logic [7:0]               fwd_addr,
  input  logic [12+CHANNEL_NUM-1:0] fwd_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [11:0]              rsp_data,
  output logic [CHANNEL_NUM-1:0]   rsp_chmask,
  output logic                     rsp_miss
`ifdef FWD_LOOKUP_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt
`endif
);

  logic                   r_s1_valid;
  logic [7:0]             r_s1_addr;
  logic [TAG_W-1:0]       r_s1_tag;

  logic                   r_rsp_valid;
  logic [TAG_W-1:0]       r_rsp_tag;
  logic [11:0]            r_rsp_data;
  logic [CHANNEL_NUM-1:0] r_rsp_chmask;
  logic                   r_rsp_miss;

  logic w_s2_free;
  logic w_s2_load;
  logic w_req_ready;
  logic w_req_fire;

  assign w_s2_free   = ~r_rsp_valid | rsp_ready;
  assign w_s2_load   = r_s1_valid & w_s2_free;
  assign w_req_ready = ~r_s1_valid | w_s2_free;
  assign w_req_fire  = req_valid & w_req_ready;

  assign req_ready  = w_req_ready;
  assign fwd_rden   = w_s2_load;
  assign fwd_addr   = r_s1_addr;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_data   = r_rsp_data;
  assign rsp_chmask = r_rsp_chmask;
  assign rsp_miss   = r_rsp_miss;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_tag   <= '0;
    end else if (w_req_fire) begin
      // A fire with S1 occupied implies S1 is moving into S2 on this same edge.
      r_s1_valid <= 1'b1;
      r_s1_addr  <= req_addr;
      r_s1_tag   <= req_tag;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // fwd_rdata is sampled here before any same-edge host write lands, giving the pre-write entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_tag    <= '0;
      r_rsp_data   <= '0;
      r_rsp_chmask <= '0;
      r_rsp_miss   <= 1'b0;
    end else if (w_s2_load) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_tag    <= r_s1_tag;
      r_rsp_data   <= fwd_rdata[11:0];
      r_rsp_chmask <= fwd_rdata[12+CHANNEL_NUM-1:12];
      r_rsp_miss   <= (fwd_rdata[12+CHANNEL_NUM-1:12] == '0);
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

`ifdef FWD_LOOKUP_STATS_EN
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic             w_rsp_fire;

  assign w_rsp_fire = r_rsp_valid & rsp_ready;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (stats_clr) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_rsp_fire) begin
      if (r_rsp_miss) begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end else begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/fwd_lookup_ctrl.md
# fwd_lookup_ctrl

Forward-path lookup controller sitting directly upstream of the host-writable lookup table. Accepts 8-bit lookup requests on a valid/ready interface, drives the table's forward read port, and splits each returned entry into a 12-bit data field and a `CHANNEL_NUM`-bit channel mask. Results are presented downstream on a valid/ready interface through a two-stage pipeline. Entries with an all-zero channel mask are flagged as misses.

## Interface
- `TAG_W`, 8, width of the opaque request tag carried alongside each lookup.
- `CNT_W`, 16, width of the hit/miss statistics counters (only when stats are compiled in).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  lookup request valid.
- `req_ready`  out  1  controller accepts a request this cycle.
- `req_addr`  in  8  table index.
- `req_tag`  in  TAG_W  passed through unchanged to the response.
- `fwd_rden`  out  1  forward read enable to the table.
- `fwd_addr`  out  8  forward read address to the table.
- `fwd_rdata`  in  12+`CHANNEL_NUM`  table entry, combinational from `fwd_addr`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  downstream accepts the response.
- `rsp_tag`  out  TAG_W  tag of the originating request.
- `rsp_data`  out  12  `fwd_rdata[11:0]`.
- `rsp_chmask`  out  `CHANNEL_NUM`  `fwd_rdata[12+CHANNEL_NUM-1:12]`.
- `rsp_miss`  out  1  high when `rsp_chmask == 0`.
- `stats_clr`  in  1  synchronous clear of the counters (stats builds only).
- `hit_cnt`, `miss_cnt`  out  CNT_W  saturating counters (stats builds only).

## Operation
- **Stage S1 (address):**
  - Registers `s1_valid`, `s1_addr`, `s1_tag`.
  - Loaded on `req_valid & req_ready`.
- **Stage S2 (result):**
  - Registers `rsp_valid`, `rsp_tag`, `rsp_data`, `rsp_chmask`, `rsp_miss`.
  - Loaded from S1 and `fwd_rdata` on `s2_load`.
- **Control equations:**
  - `s2_free = ~rsp_valid | rsp_ready`.
  - `s2_load = s1_valid & s2_free`.
  - `req_ready = ~s1_valid | s2_free`, so full throughput is one lookup per cycle.
  - `fwd_addr = s1_addr`, driven combinationally; `fwd_rden = s2_load`.
- **Stall:** while `rsp_valid & ~rsp_ready`, S2 holds and S1 holds. `req_ready` is then 0 if S1 is occupied.
- **Draining:** if `rsp_ready` is high and S1 is empty, `rsp_valid` deasserts on the next edge.
- **Ordering:** responses are returned strictly in request order. Nothing is dropped or duplicated.
- **Miss:** a miss is still a normal response: `rsp_data` is passed as read and `rsp_miss` = 1.
- **Host write collision:** the table writes at the clock edge and the read is combinational. When a host write to `s1_addr` happens on the same edge as `s2_load`, S2 captures the pre-write entry.

## Timing
- Latency is 2 cycles: request accepted at edge N, `rsp_valid` high after edge N+1 when unstalled.
- Reset values while `rst_n` is low:
  - `s1_valid`, `rsp_valid` = 0.
  - All data registers = 0, so `rsp_miss` = 0.
  - `req_ready` = 1; `fwd_rden` = 0; `fwd_addr` = 0.
  - Counters = 0.
- Reset asserted mid-operation discards in-flight lookups immediately; no response is produced for them.
- `rsp_*` payload is stable while `rsp_valid & ~rsp_ready`.

## Configuration
- Macro `FWD_LOOKUP_STATS_EN`.
- **Defined:**
  - `hit_cnt`, `miss_cnt` and `stats_clr` exist.
  - Counting happens on each S2 handshake (`rsp_valid & rsp_ready`): `miss_cnt` increments if `rsp_miss`, else `hit_cnt` increments.
  - Counters saturate at all-ones.
  - `stats_clr` takes priority over a same-cycle increment: the result is 0.
- **Undefined:** those ports and counters are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n` low with `req_valid` = 1 -> `req_ready` = 1, `rsp_valid` = 0, `fwd_rden` = 0, counters 0.
- **Single lookup:**
  - Setup: entry 0x05 holds mask 0b0011, data 0xABC; request addr 0x05, tag 0x11 at edge N.
  - Expected: `fwd_addr` = 0x05 in cycle N+1; after edge N+1, `rsp_valid` = 1, tag 0x11, data 0xABC, mask 0b0011, `rsp_miss` = 0.
- **Back-to-back with stall:**
  - Setup: issue addrs 0x01, 0x02, 0x03 on consecutive cycles; hold `rsp_ready` = 0 for 3 cycles.
  - Expected: `req_ready` drops once S1 and S2 are full; after release, three responses arrive in order with correct tags and no loss.
- **Miss:** entry 0x10 = all zeros, request it -> `rsp_miss` = 1, `rsp_chmask` = 0; with stats, `miss_cnt` = 1 and `hit_cnt` = 0.
- **Stats saturation and clear (stats build, CNT_W = 4):**
  - 17 hits -> `hit_cnt` = 15.
  - `stats_clr` on the same cycle as a hit handshake -> `hit_cnt` = 0.
- **Write collision:**
  - Setup: entry 0x20 = data 0x111; host writes data 0x222 to 0x20 on the same edge as `s2_load` for addr 0x20.
  - Expected: response data 0x111; the next lookup of 0x20 returns 0x222.
